// File: rtl/fetch_instruction_memory.sv
// Byte-addressed little-endian instruction store with a registered one-cycle
// fetch, valid/ready handshake, program-load port, fault reporting and flush.
module fetch_instruction_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 65536,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INSTR_WIDTH-1:0] rsp_instr,
    output logic [ADDR_WIDTH-1:0]  rsp_addr,
    output logic                   rsp_fault,
    input  logic                   flush,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [31:0]            prog_wdata,
    input  logic [3:0]             prog_be
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

    if (INSTR_WIDTH != 32) begin : g_bad_instr_width
        $error("fetch_instruction_memory: INSTR_WIDTH must be 32");
    end

    if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
        $error("fetch_instruction_memory: DEPTH_BYTES must be a power of two >= 4");
    end

    logic [7:0]            mem [DEPTH_BYTES];
    logic                  accept;
    logic                  req_fault;
    logic [IDX_W-1:0]      rd_base;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic [IDX_W-1:0]      wr_base;
    logic                  wr_in_range;

    assign req_ready   = !rsp_valid || rsp_ready;
    assign accept      = req_valid && req_ready;
    assign req_fault   = (req_addr[1:0] != 2'b00) || (req_addr > LAST_WORD);
    assign rd_base     = req_addr[IDX_W-1:0];
    assign wr_word     = prog_addr & ~ADDR_WIDTH'(3);
    assign wr_base     = wr_word[IDX_W-1:0];
    assign wr_in_range = (wr_word <= LAST_WORD);

    // Writes land via NBA, so a fetch accepted on the same edge reads the old bytes.
    always_ff @(posedge clk) begin
        if (prog_we && wr_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (prog_be[i]) begin
                    mem[wr_base | IDX_W'(i)] <= prog_wdata[8*i +: 8];
                end
            end
        end
    end

    // A same-edge accept wins over flush, so flush only discards older work.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= req_addr;
            rsp_fault <= req_fault;
            if (req_fault) begin
                rsp_instr <= '0;
            end else begin
                rsp_instr <= {mem[rd_base | IDX_W'(3)], mem[rd_base | IDX_W'(2)],
                              mem[rd_base | IDX_W'(1)], mem[rd_base]};
            end
        end else if (flush || rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_instruction_memory.sv
// Randomised self-checking bench for fetch_instruction_memory against a
// byte-array reference model of the instruction store and response slot.
module tb_fetch_instruction_memory;

    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int LAST  = DEPTH - 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic          rsp_fault;
    logic          flush;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;
    logic [3:0]    prog_be;

    logic [7:0]    model_mem [DEPTH];
    logic          m_valid;
    logic [31:0]   m_instr;
    logic [AW-1:0] m_addr;
    logic          m_fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_instruction_memory #(
        .ADDR_WIDTH (AW),
        .DEPTH_BYTES(DEPTH),
        .INSTR_WIDTH(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .prog_be   (prog_be)
    );

    always #5 clk = ~clk;

    // Advances one rising edge and moves the reference model by the behavioural rules.
    task automatic tick();
        logic        acc;
        logic        flt;
        logic [31:0] rd;
        logic [31:0] wa;
        int          base;
        acc = req_valid && (!m_valid || rsp_ready);
        flt = (req_addr[1:0] != 2'b00) || (req_addr > 32'(LAST));
        rd  = 32'h0;
        if (!flt) begin
            base = int'(req_addr);
            for (int i = 0; i < 4; i++) rd[8*i +: 8] = model_mem[base + i];
        end
        wa = prog_addr & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_addr  = '0;
            m_fault = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_instr = rd;
            m_addr  = req_addr;
            m_fault = flt;
        end else if (flush || rsp_ready) begin
            m_valid = 1'b0;
        end
        if (prog_we && wa <= 32'(LAST)) begin
            for (int i = 0; i < 4; i++)
                if (prog_be[i]) model_mem[int'(wa) + i] = prog_wdata[8*i +: 8];
        end
    endtask

    task automatic idle_inputs();
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b1;
        flush      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        prog_be    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset   = 1'b1;
        m_valid = 1'b0;
        m_instr = '0;
        m_addr  = '0;
        m_fault = 1'b0;
        for (int w = 0; w < DEPTH / 4; w++) begin
            prog_we    = 1'b1;
            prog_addr  = 32'(w * 4);
            prog_wdata = $urandom;
            prog_be    = 4'hF;
            tick();
        end
        reset   = 1'b0;
        prog_we = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got v=%b f=%b a=%h i=%h, expected all zero",
                     rsp_valid, rsp_fault, rsp_addr, rsp_instr);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_load_fetch();
        prog_we    = 1'b1;
        prog_addr  = 32'h0;
        prog_wdata = 32'h0050_0093;
        prog_be    = 4'hF;
        tick();
        prog_we   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b1, 1'b0, 32'h0, 32'h0050_0093}) begin
            n_fail++;
            $display("[TB] FAIL load_fetch: got v=%b f=%b a=%h i=%h expected v=1 f=0 a=0 i=00500093",
                     rsp_valid, rsp_fault, rsp_addr, rsp_instr);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_instr} !== {1'b0, 32'h0050_0093}) begin
            n_fail++;
            $display("[TB] FAIL retire_hold: got v=%b i=%h expected v=0 i=00500093",
                     rsp_valid, rsp_instr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h0050_0093;
        words[1] = 32'h0050_0113;
        words[2] = 32'h00A0_0193;
        for (int k = 0; k < 3; k++) begin
            prog_we    = 1'b1;
            prog_addr  = 32'(k * 4);
            prog_wdata = words[k];
            prog_be    = 4'hF;
            tick();
        end
        prog_we   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'(k * 4);
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", k, req_ready);
            end
            tick();
            n_checks++;
            if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b1, 1'b0, 32'(k * 4), words[k]}) begin
                n_fail++;
                $display("[TB] FAIL b2b_rsp[%0d]: got v=%b a=%h i=%h expected v=1 a=%h i=%h",
                         k, rsp_valid, rsp_addr, rsp_instr, 32'(k * 4), words[k]);
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        rsp_ready = 1'b0;
        req_addr  = 32'h4;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", c, req_ready);
            end
            tick();
            n_checks++;
            if ({rsp_valid, rsp_addr, rsp_instr} !== {1'b1, 32'h0, m_instr} || m_addr !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b a=%h i=%h expected v=1 a=0 i=%h",
                         c, rsp_valid, rsp_addr, rsp_instr, m_instr);
            end
        end
        rsp_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            req_addr = 32'(k * 4);
            tick();
            n_checks++;
            if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b1, 1'b0, 32'(k * 4), m_instr}
                || m_addr !== 32'(k * 4)) begin
                n_fail++;
                $display("[TB] FAIL resume[%0d]: got v=%b a=%h i=%h expected v=1 a=%h i=%h",
                         k, rsp_valid, rsp_addr, rsp_instr, 32'(k * 4), m_instr);
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_faults();
        logic [31:0] addrs [6];
        logic        flts  [6];
        addrs[0] = 32'h2;         flts[0] = 1'b1;
        addrs[1] = 32'h40;        flts[1] = 1'b1;
        addrs[2] = 32'h3C;        flts[2] = 1'b0;
        addrs[3] = 32'hFFFF_FFFC; flts[3] = 1'b1;
        addrs[4] = 32'h1_0000_000 >> 0; flts[4] = 1'b1;
        addrs[5] = 32'h3D;        flts[5] = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_addr = addrs[k];
            tick();
            n_checks++;
            if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b1, flts[k], addrs[k], m_instr}
                || (flts[k] && m_instr !== 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL fault[%0d]: got v=%b f=%b a=%h i=%h expected v=1 f=%b a=%h i=%h",
                         k, rsp_valid, rsp_fault, rsp_addr, rsp_instr, flts[k], addrs[k], m_instr);
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_partial_write();
        logic [31:0] word0;
        prog_we    = 1'b1;
        prog_addr  = 32'h1B;
        prog_wdata = 32'h0010_0293;
        prog_be    = 4'hF;
        tick();
        prog_addr  = 32'h18;
        prog_wdata = 32'hFFFF_FFFF;
        prog_be    = 4'b0101;
        req_valid  = 1'b1;
        req_addr   = 32'h18;
        rsp_ready  = 1'b1;
        tick();
        prog_we = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_instr} !== {1'b1, 32'h0010_0293}) begin
            n_fail++;
            $display("[TB] FAIL collision_old: got v=%b i=%h expected v=1 i=00100293",
                     rsp_valid, rsp_instr);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_instr} !== {1'b1, 32'h00FF_02FF}) begin
            n_fail++;
            $display("[TB] FAIL partial_write: got v=%b i=%h expected v=1 i=00ff02ff",
                     rsp_valid, rsp_instr);
        end
        word0      = {model_mem[3], model_mem[2], model_mem[1], model_mem[0]};
        req_valid  = 1'b0;
        prog_we    = 1'b1;
        prog_addr  = 32'h40;
        prog_wdata = ~word0;
        prog_be    = 4'hF;
        tick();
        prog_we   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_instr} !== {1'b1, word0}) begin
            n_fail++;
            $display("[TB] FAIL oob_load_ignored: got v=%b i=%h expected v=1 i=%h",
                     rsp_valid, rsp_instr, word0);
        end
        tick();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_alone: got v=%b expected 0", rsp_valid);
        end
        req_valid = 1'b1;
        req_addr  = 32'h4;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_ready: got %b expected 1", req_ready);
        end
        tick();
        flush = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b1, 1'b0, 32'h4, m_instr}
            || m_addr !== 32'h4) begin
            n_fail++;
            $display("[TB] FAIL flush_accept: got v=%b a=%h i=%h expected v=1 a=4 i=%h",
                     rsp_valid, rsp_addr, rsp_instr, m_instr);
        end
        req_addr = 32'hC;
        flush    = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_addr} !== {1'b0, 32'h4}) begin
            n_fail++;
            $display("[TB] FAIL flush_stalled: got v=%b a=%h expected v=0 a=4", rsp_valid, rsp_addr);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        tick();
        req_valid  = 1'b0;
        reset      = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = 32'h10;
        prog_wdata = $urandom;
        prog_be    = 4'hF;
        tick();
        reset   = 1'b0;
        prog_we = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: got v=%b f=%b a=%h i=%h expected all zero",
                     rsp_valid, rsp_fault, rsp_addr, rsp_instr);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_instr} !== {1'b1, prog_wdata}) begin
            n_fail++;
            $display("[TB] FAIL reset_write: got v=%b i=%h expected v=1 i=%h",
                     rsp_valid, rsp_instr, prog_wdata);
        end
        tick();
    endtask

    task automatic test_random();
        int sel;
        for (int c = 0; c < 300; c++) begin
            sel        = int'($urandom_range(0, 9));
            reset      = ($urandom_range(0, 40) == 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            rsp_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            prog_we    = ($urandom_range(0, 4) == 0);
            prog_addr  = (sel == 0) ? 32'h44 : 32'($urandom_range(0, DEPTH - 1));
            prog_wdata = $urandom;
            prog_be    = 4'($urandom);
            if (sel < 7) req_addr = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
            else if (sel < 9) req_addr = 32'($urandom_range(0, DEPTH + 15));
            else req_addr = $urandom;
            #1;
            n_checks++;
            if (req_ready !== (!m_valid || rsp_ready)) begin
                n_fail++;
                $display("[TB] FAIL rand_ready[%0d]: got %b expected %b",
                         c, req_ready, !m_valid || rsp_ready);
            end
            tick();
            n_checks++;
            if ({rsp_valid, rsp_fault, rsp_addr, rsp_instr} !== {m_valid, m_fault, m_addr, m_instr}) begin
                n_fail++;
                $display("[TB] FAIL rand_rsp[%0d]: got v=%b f=%b a=%h i=%h expected v=%b f=%b a=%h i=%h",
                         c, rsp_valid, rsp_fault, rsp_addr, rsp_instr, m_valid, m_fault, m_addr, m_instr);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_backpressure();
        test_faults();
        test_partial_write();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
